// File: rtl/bus_pkg.sv
// Shared definitions for the two-master serial bus arbiter.
//   - bus_state_t : sequencer state encoding
//   - bus_mode_t  : transfer direction carried on the serial mode line
//   - GRANT_M1/M2 : encoding of the last-granted master
//   - default widths / timeout and a constant-evaluable clog2
package bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_WDATA   = 3'd2,
        ST_RDATA   = 3'd3,
        ST_RELEASE = 3'd4
    } bus_state_t;

    typedef enum logic {
        MODE_READ  = 1'b0,
        MODE_WRITE = 1'b1
    } bus_mode_t;

    localparam logic GRANT_M1 = 1'b0;
    localparam logic GRANT_M2 = 1'b1;

    localparam int BUS_ADDR_WIDTH = 12;
    localparam int BUS_DATA_WIDTH = 8;
    localparam int BUS_TIMEOUT    = 64;

    // Number of bits needed to hold values 0 .. value-1 (at least 1).
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick.
//   req1, req2  : requests from master 1 / master 2
//   last_grant  : master granted most recently (GRANT_M1 / GRANT_M2)
//   pick1/pick2 : one-hot winner, both low when nobody requests
module rr_arb2
    import bus_pkg::*;
(
    input  logic req1,
    input  logic req2,
    input  logic last_grant,
    output logic pick1,
    output logic pick2
);

    // On contention the master that did not win last time goes first.
    always_comb begin
        pick1 = req1 && (!req2 || (last_grant == GRANT_M2));
        pick2 = req2 && (!req1 || (last_grant == GRANT_M1));
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter and sequencer for the shared serial system bus.
// Grants the bus round-robin, muxes the granted master onto the bus,
// follows the transfer bit by bit (address, then write or read data)
// to release the grant exactly at the end, and aborts stalled grants.
//   clk, rst                     : clock, synchronous active-high reset
//   breq1/2                      : bus requests
//   bgrant1/2                    : registered grants, at most one high
//   m1_*/m2_* wdata,mode,mvalid  : serial signals from each master
//   m1_*/m2_* rdata,svalid       : read data returned to each master
//   bus_wdata/mode/mvalid        : granted master's signals to the slaves
//   bus_rdata/svalid/sready      : slave read data, valid and idle flag
//   busy                         : a grant is active
//   timeout                      : one-cycle pulse on watchdog abort
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
    parameter int DATA_WIDTH = BUS_DATA_WIDTH,
    parameter int TIMEOUT    = BUS_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic breq1,
    input  logic breq2,
    output logic bgrant1,
    output logic bgrant2,
    input  logic m1_wdata,
    input  logic m2_wdata,
    input  logic m1_mode,
    input  logic m2_mode,
    input  logic m1_mvalid,
    input  logic m2_mvalid,
    output logic m1_rdata,
    output logic m2_rdata,
    output logic m1_svalid,
    output logic m2_svalid,
    output logic bus_wdata,
    output logic bus_mode,
    output logic bus_mvalid,
    input  logic bus_rdata,
    input  logic bus_svalid,
    input  logic bus_sready,
    output logic busy,
    output logic timeout
);

    localparam int MAX_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int BIT_CNT_W = clog2(MAX_WIDTH + 1);
    localparam int WD_W      = clog2(TIMEOUT);

    localparam logic [BIT_CNT_W-1:0] ADDR_LAST = BIT_CNT_W'(ADDR_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [WD_W-1:0]      WD_LAST   = WD_W'(TIMEOUT - 1);

    bus_state_t           state_q, state_d;
    logic                 bgrant1_q, bgrant1_d;
    logic                 bgrant2_q, bgrant2_d;
    logic                 last_grant_q, last_grant_d;
    logic                 mode_q, mode_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
    logic                 timeout_q, timeout_d;
    logic                 busy_q, busy_d;

    logic pick1, pick2;
    logic g_breq;
    logic g_svalid;
    logic activity;
    logic mode_eff;
    logic end_grant;

    rr_arb2 u_rr_arb2 (
        .req1       (breq1),
        .req2       (breq2),
        .last_grant (last_grant_q),
        .pick1      (pick1),
        .pick2      (pick2)
    );

    // Bus mux driven from the registered grant; the ungranted master is
    // invisible to both the slaves and the sequencer.
    always_comb begin
        bus_wdata  = 1'b0;
        bus_mode   = 1'b0;
        bus_mvalid = 1'b0;
        g_breq     = 1'b0;
        if (bgrant1_q) begin
            bus_wdata  = m1_wdata;
            bus_mode   = m1_mode;
            bus_mvalid = m1_mvalid;
            g_breq     = breq1;
        end else if (bgrant2_q) begin
            bus_wdata  = m2_wdata;
            bus_mode   = m2_mode;
            bus_mvalid = m2_mvalid;
            g_breq     = breq2;
        end
        m1_rdata  = bgrant1_q & bus_rdata;
        m1_svalid = bgrant1_q & bus_svalid;
        m2_rdata  = bgrant2_q & bus_rdata;
        m2_svalid = bgrant2_q & bus_svalid;
        g_svalid  = (bgrant1_q | bgrant2_q) & bus_svalid;
        activity  = bus_mvalid | g_svalid;
    end

    always_comb begin
        state_d      = state_q;
        bgrant1_d    = bgrant1_q;
        bgrant2_d    = bgrant2_q;
        last_grant_d = last_grant_q;
        mode_d       = mode_q;
        bit_cnt_d    = bit_cnt_q;
        wd_cnt_d     = wd_cnt_q;
        timeout_d    = 1'b0;
        end_grant    = 1'b0;
        // With a one-bit address the direction must come from this very bit.
        mode_eff     = (bit_cnt_q == '0) ? bus_mode : mode_q;

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                wd_cnt_d  = '0;
                if (pick1 || pick2) begin
                    state_d      = ST_ADDR;
                    bgrant1_d    = pick1;
                    bgrant2_d    = pick2;
                    last_grant_d = pick2 ? GRANT_M2 : GRANT_M1;
                end
            end
            ST_ADDR: begin
                // A master may withdraw only before its first bit.
                if ((bit_cnt_q == '0) && !g_breq) begin
                    end_grant = 1'b1;
                end else if (bus_mvalid) begin
                    if (bit_cnt_q == '0) begin
                        mode_d = bus_mode;
                    end
                    if (bit_cnt_q == ADDR_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (mode_eff == MODE_WRITE) ? ST_WDATA : ST_RDATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_WDATA: begin
                if (bus_mvalid) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = ST_RELEASE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_RDATA: begin
                if (g_svalid) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = ST_RELEASE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                if (bus_sready) begin
                    end_grant = 1'b1;
                end
            end
            default: begin
                end_grant = 1'b1;
            end
        endcase

        // Any bit movement restarts the watchdog, so a completing bit always
        // beats an expiry on the same edge. A normal release also suppresses it.
        if (state_q != ST_IDLE) begin
            if (activity) begin
                wd_cnt_d = '0;
            end else if ((wd_cnt_q == WD_LAST) && !end_grant) begin
                timeout_d = 1'b1;
                end_grant = 1'b1;
            end else begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end

        // last_grant is left alone so an aborted master still loses the next tie.
        if (end_grant) begin
            state_d   = ST_IDLE;
            bgrant1_d = 1'b0;
            bgrant2_d = 1'b0;
            bit_cnt_d = '0;
            wd_cnt_d  = '0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bgrant1_q    <= 1'b0;
            bgrant2_q    <= 1'b0;
            last_grant_q <= GRANT_M2;
            mode_q       <= MODE_READ;
            bit_cnt_q    <= '0;
            wd_cnt_q     <= '0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bgrant1_q    <= bgrant1_d;
            bgrant2_q    <= bgrant2_d;
            last_grant_q <= last_grant_d;
            mode_q       <= mode_d;
            bit_cnt_q    <= bit_cnt_d;
            wd_cnt_q     <= wd_cnt_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
        end
    end

    assign bgrant1 = bgrant1_q;
    assign bgrant2 = bgrant2_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter. Stimulus pushes expected events
// (grant changes, timeout pulses, read bits) and output snapshots tagged
// with the cycle they must appear in; a negedge monitor pops and compares.
module tb_bus_arbiter;

    localparam int TMO      = 16;
    localparam int EV_GRANT = 0;
    localparam int EV_TMO   = 1;
    localparam int EV_RBIT  = 2;

    typedef struct {
        int         kind;
        logic [3:0] val;
        int         cyc;
    } ev_t;

    typedef struct {
        logic [10:0] val;
        int          cyc;
    } snap_t;

    logic clk = 1'b0;
    logic rst;
    logic breq1, breq2, bgrant1, bgrant2;
    logic m1_wdata, m2_wdata, m1_mode, m2_mode, m1_mvalid, m2_mvalid;
    logic m1_rdata, m2_rdata, m1_svalid, m2_svalid;
    logic bus_wdata, bus_mode, bus_mvalid, bus_rdata, bus_svalid, bus_sready;
    logic busy, timeout;

    logic rr_r1, rr_r2, rr_lg, rr_p1, rr_p2;
    logic [1:0] rr_tbl [8];

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         mon_en = 1'b0;
    logic [1:0] g_prev = 2'b00;
    logic [1:0] exp_g = 2'b00;
    ev_t        exp_q[$];
    snap_t      snap_q[$];

    bus_arbiter #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (8),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .breq1      (breq1),
        .breq2      (breq2),
        .bgrant1    (bgrant1),
        .bgrant2    (bgrant2),
        .m1_wdata   (m1_wdata),
        .m2_wdata   (m2_wdata),
        .m1_mode    (m1_mode),
        .m2_mode    (m2_mode),
        .m1_mvalid  (m1_mvalid),
        .m2_mvalid  (m2_mvalid),
        .m1_rdata   (m1_rdata),
        .m2_rdata   (m2_rdata),
        .m1_svalid  (m1_svalid),
        .m2_svalid  (m2_svalid),
        .bus_wdata  (bus_wdata),
        .bus_mode   (bus_mode),
        .bus_mvalid (bus_mvalid),
        .bus_rdata  (bus_rdata),
        .bus_svalid (bus_svalid),
        .bus_sready (bus_sready),
        .busy       (busy),
        .timeout    (timeout)
    );

    rr_arb2 u_rr (
        .req1       (rr_r1),
        .req2       (rr_r2),
        .last_grant (rr_lg),
        .pick1      (rr_p1),
        .pick2      (rr_p2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish by cycle %0d, required finish", cyc);
        $fatal(1, "bench time limit");
    end

    function automatic string ev_name(input int k);
        case (k)
            EV_GRANT: return "grant";
            EV_TMO:   return "timeout";
            default:  return "rbit";
        endcase
    endfunction

    task automatic check_ev(input int kind, input logic [3:0] val);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_%s cyc=%0d got val=%b, required no event", ev_name(kind), cyc, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val || e.cyc != cyc) begin
                n_bad++;
                $display("FAIL event_%s: got %s val=%b at cyc %0d, required %s val=%b at cyc %0d",
                         ev_name(e.kind), ev_name(kind), val, cyc, ev_name(e.kind), e.val, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        logic [1:0]  g;
        logic [10:0] outs;
        snap_t       s;
        if (mon_en) begin
            g = {bgrant2, bgrant1};
            n_cmp++;
            if (bgrant1 && bgrant2) begin
                n_bad++;
                $display("FAIL grant_exclusive cyc=%0d got bgrant1=%b bgrant2=%b, required not both", cyc, bgrant1, bgrant2);
            end
            if (g !== g_prev) check_ev(EV_GRANT, {2'b00, g});
            g_prev = g;
            if (timeout) check_ev(EV_TMO, 4'b0000);
            if (m1_svalid || m2_svalid) check_ev(EV_RBIT, {m2_svalid, m1_svalid, m2_rdata, m1_rdata});
            outs = {bgrant1, bgrant2, busy, timeout, bus_wdata, bus_mode, bus_mvalid,
                    m1_rdata, m1_svalid, m2_rdata, m2_svalid};
            while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
                s = snap_q.pop_front();
                n_cmp++;
                if (outs !== s.val || s.cyc != cyc) begin
                    n_bad++;
                    $display("FAIL snapshot cyc=%0d got=%b required=%b (due cyc %0d)", cyc, outs, s.val, s.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int kind, input logic [3:0] val, input int c);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic push_grant(input logic [1:0] g, input int c);
        push_ev(EV_GRANT, {2'b00, g}, c);
        exp_g = g;
    endtask

    task automatic push_snap(input logic [10:0] v, input int c);
        snap_t s;
        s.val = v;
        s.cyc = c;
        snap_q.push_back(s);
    endtask

    // Outputs while master m holds the bus with nothing moving on it.
    function automatic logic [10:0] busy_vec(input int m);
        return {(m == 1), (m == 2), 1'b1, 8'b0};
    endfunction

    task automatic drive_m(input int m, input logic mv, input logic wd, input logic md);
        if (m == 1) begin
            m1_mvalid = mv; m1_wdata = wd; m1_mode = md;
        end else begin
            m2_mvalid = mv; m2_wdata = wd; m2_mode = md;
        end
    endtask

    task automatic set_breq(input int m, input logic v);
        if (m == 1) breq1 = v;
        else        breq2 = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        breq1 = 0; breq2 = 0;
        drive_m(1, 0, 0, 0);
        drive_m(2, 0, 0, 0);
        bus_rdata = 0; bus_svalid = 0; bus_sready = 0;
        if (exp_g != 2'b00) push_grant(2'b00, cyc + 1);
        push_snap(11'b0, cyc + 1);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Raise requests now; the winner's grant must show on the next cycle.
    task automatic request(input logic b1, input logic b2, input int winner);
        breq1 = b1;
        breq2 = b2;
        push_grant((winner == 1) ? 2'b01 : 2'b10, cyc + 1);
        tick();
    endtask

    task automatic send_bits(input int m, input logic [31:0] val, input int n,
                             input logic md, input bit drop_req);
        for (int i = 0; i < n; i++) begin
            drive_m(m, 1'b1, val[n-1-i], md);
            if (i == 0)
                push_snap({(m == 1), (m == 2), 1'b1, 1'b0, val[n-1-i], md, 1'b1, 4'b0}, cyc);
            tick();
            if (i == 0 && drop_req) set_breq(m, 1'b0);
        end
        drive_m(m, 0, 0, 0);
    endtask

    task automatic rbits(input int m, input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            bus_svalid = 1'b1;
            bus_rdata  = d[7-i];
            push_ev(EV_RBIT, {(m == 2), (m == 1), (m == 2) & d[7-i], (m == 1) & d[7-i]}, cyc);
            tick();
        end
        bus_svalid = 1'b0;
        bus_rdata  = 1'b0;
    endtask

    // Slave reports idle now; the grant must fall on the next cycle.
    task automatic bus_release(input int m);
        bus_sready = 1'b1;
        push_snap(busy_vec(m), cyc);
        push_grant(2'b00, cyc + 1);
        tick();
        bus_sready = 1'b0;
        push_snap(11'b0, cyc);
    endtask

    task automatic do_write(input int m, input logic [11:0] addr, input logic [7:0] data,
                            input int delay, input bit noise, input bit drop_req);
        if (noise) drive_m(3 - m, 1'b1, 1'b1, 1'b0);
        send_bits(m, {12'b0, addr, data}, 20, 1'b1, drop_req);
        for (int d = 0; d < delay; d++) begin
            push_snap(busy_vec(m), cyc);
            tick();
        end
        bus_release(m);
        if (noise) drive_m(3 - m, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [11:0] addr_tbl [4];
        logic [7:0]  data_tbl [4];
        int          m;

        addr_tbl = '{12'h123, 12'hFFF, 12'h800, 12'h001};
        data_tbl = '{8'hA5, 8'h00, 8'hFF, 8'h81};
        // index {req1, req2, last_grant_is_m2} -> {pick1, pick2}
        rr_tbl   = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10};

        rst = 1'b1;
        breq1 = 0; breq2 = 0;
        drive_m(1, 0, 0, 0);
        drive_m(2, 0, 0, 0);
        bus_rdata = 0; bus_svalid = 0; bus_sready = 0;
        rr_r1 = 0; rr_r2 = 0; rr_lg = 0;
        tick();
        mon_en = 1'b1;

        // Round-robin picker, all eight input combinations.
        for (int i = 0; i < 8; i++) begin
            {rr_r1, rr_r2, rr_lg} = i[2:0];
            #1;
            n_cmp++;
            if ({rr_p1, rr_p2} !== rr_tbl[i]) begin
                n_bad++;
                $display("FAIL rr_arb2 idx=%0d got=%b required=%b", i, {rr_p1, rr_p2}, rr_tbl[i]);
            end
        end

        // Single master write: 12 address + 8 data bits, slow slave.
        do_reset();
        request(1'b1, 1'b0, 1);
        do_write(1, 12'hABC, 8'h5A, 2, 1'b0, 1'b1);
        repeat (2) tick();

        // Both masters requesting: grants alternate, ungranted master is noise.
        do_reset();
        request(1'b1, 1'b1, 1);
        for (int t = 0; t < 4; t++) begin
            m = (t % 2 == 0) ? 1 : 2;
            do_write(m, addr_tbl[t], data_tbl[t], t, 1'b1, 1'b0);
            if (t < 3) begin
                push_grant((m == 1) ? 2'b10 : 2'b01, cyc + 1);
                tick();
            end else begin
                breq1 = 0;
                breq2 = 0;
            end
        end
        repeat (2) tick();

        // Master 2 reads 0x0A5, slave returns 0x3C.
        do_reset();
        request(1'b0, 1'b1, 2);
        send_bits(2, 32'h0A5, 12, 1'b0, 1'b1);
        rbits(2, 8'h3C, 8);
        bus_release(2);
        repeat (2) tick();

        // Master 1 withdraws before its first bit; pending master 2 follows.
        do_reset();
        request(1'b1, 1'b1, 1);
        breq1 = 0;
        push_grant(2'b00, cyc + 1);
        push_grant(2'b10, cyc + 2);
        tick();
        tick();
        breq2 = 0;
        push_grant(2'b00, cyc + 1);
        tick();
        repeat (2) tick();

        // Master 1 stalls after 5 address bits: watchdog abort.
        do_reset();
        request(1'b1, 1'b0, 1);
        send_bits(1, 32'b10110, 5, 1'b1, 1'b1);
        push_grant(2'b00, cyc + TMO);
        push_ev(EV_TMO, 4'b0000, cyc + TMO);
        push_snap({3'b000, 1'b1, 7'b0}, cyc + TMO);
        repeat (TMO + 4) tick();

        // Reset during a read, then last_grant must favour master 1 again.
        do_reset();
        request(1'b1, 1'b0, 1);
        send_bits(1, 32'h123, 12, 1'b0, 1'b1);
        rbits(1, 8'hA0, 3);
        do_reset();
        request(1'b1, 1'b1, 1);
        breq1 = 0;
        breq2 = 0;
        push_grant(2'b00, cyc + 1);
        tick();
        repeat (4) tick();

        n_cmp++;
        if (exp_q.size() != 0 || snap_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_expectations: got %0d events and %0d snapshots left, required 0",
                     exp_q.size(), snap_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
